// File: rtl/bpu_pkg.sv
// Shared types and helpers for the gshare branch predictor.
package bpu_pkg;

  // 2-bit saturating counter states; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } sat2_e;

  // Widest history supported; GHR helpers work at this width and callers truncate.
  localparam int unsigned GHR_MAX_W = 12;

  // Move a 2-bit counter one step toward the resolved outcome, saturating at both ends.
  function automatic logic [1:0] sat2_next(input logic [1:0] st, input logic taken);
    logic [1:0] nxt;
    nxt = st;
    case (st)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = st;
    endcase
    return nxt;
  endfunction

  // Shift a new outcome into the LSB of a history register.
  function automatic logic [GHR_MAX_W-1:0] ghr_shift(input logic [GHR_MAX_W-1:0] ghr,
                                                     input logic bit_in);
    return {ghr[GHR_MAX_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/bpu_sat_cnt.sv
// Saturating event counter with stall freeze.
module bpu_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count up on inc, stick at all-ones, freeze while stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall_i && inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gshare_bpu.sv
// Global-history (gshare / pure GHR) branch predictor with speculative and
// architectural history and saturating performance counters.
module gshare_bpu
  import bpu_pkg::*;
#(
  parameter int unsigned HIST_W  = 2,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned PC_LSB  = 2,
  parameter bit          GSHARE  = 1'b1,
  parameter int unsigned CNT_W   = 16,
  parameter logic [1:0]  INIT_ST = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              if_br,
  input  logic [PC_W-1:0]   if_pc,
  output logic              br_pre,
  output logic [HIST_W-1:0] pred_idx,
  input  logic              ex_br,
  input  logic              ex_taken,
  input  logic              ex_mispred,
  input  logic [HIST_W-1:0] ex_idx,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned DEPTH = 1 << HIST_W;

  logic [1:0]           pht_q [DEPTH];
  logic [HIST_W-1:0]    spec_ghr_q, spec_ghr_d;
  logic [HIST_W-1:0]    arch_ghr_q, arch_ghr_d;
  logic [GHR_MAX_W-1:0] arch_sh, spec_sh;
  logic                 upd_en;
  logic                 unused_bits;

  assign upd_en = ex_br && !stall;

  // Prediction: index from history (optionally hashed with PC), MSB of counter.
  always_comb begin
    if (GSHARE) pred_idx = if_pc[PC_LSB +: HIST_W] ^ spec_ghr_q;
    else        pred_idx = spec_ghr_q;
    br_pre = if_br & pht_q[pred_idx][1];
  end

  // History next state: resolve shifts arch; mispredict restores spec from the
  // freshly shifted arch value and overrides any same-cycle speculative shift.
  always_comb begin
    arch_sh    = ghr_shift(GHR_MAX_W'(arch_ghr_q), ex_taken);
    spec_sh    = ghr_shift(GHR_MAX_W'(spec_ghr_q), br_pre);
    arch_ghr_d = arch_ghr_q;
    spec_ghr_d = spec_ghr_q;
    if (!stall) begin
      if (ex_br) arch_ghr_d = arch_sh[HIST_W-1:0];
      if (ex_br && ex_mispred) spec_ghr_d = arch_sh[HIST_W-1:0];
      else if (if_br)          spec_ghr_d = spec_sh[HIST_W-1:0];
    end
  end

  // History registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_ghr_q <= '0;
      arch_ghr_q <= '0;
    end else begin
      spec_ghr_q <= spec_ghr_d;
      arch_ghr_q <= arch_ghr_d;
    end
  end

  // PHT: train the resolved entry on every branch; reads see the old value this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) pht_q[i] <= INIT_ST;
    end else if (upd_en) begin
      pht_q[ex_idx] <= sat2_next(pht_q[ex_idx], ex_taken);
    end
  end

  bpu_sat_cnt #(.CNT_W(CNT_W)) u_br_cnt (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall),
    .inc_i   (ex_br),
    .cnt_o   (br_cnt)
  );

  bpu_sat_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall),
    .inc_i   (ex_br & ex_mispred),
    .cnt_o   (miss_cnt)
  );

  assign unused_bits = ^{if_pc, arch_sh, spec_sh};

endmodule

// File: tb/tb_gshare_bpu.sv
// Randomized self-checking bench: two predictor configurations driven by shared
// stimulus and compared every cycle against an integer reference model.
module tb_gshare_bpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, if_br, ex_br, ex_taken, ex_mispred;
  logic [31:0] if_pc;
  logic [2:0]  ex_idx;

  // Config A: gshare, 8 entries, 4-bit counters. Config B: pure GHR, 4 entries, 2-bit counters.
  logic       pre_a, pre_b;
  logic [2:0] idx_a;
  logic [1:0] idx_b;
  logic [3:0] br_a, miss_a;
  logic [1:0] br_b, miss_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gshare_bpu #(.HIST_W(3), .PC_W(32), .PC_LSB(2), .GSHARE(1'b1), .CNT_W(4), .INIT_ST(2'b01)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .if_br(if_br), .if_pc(if_pc),
    .br_pre(pre_a), .pred_idx(idx_a), .ex_br(ex_br), .ex_taken(ex_taken),
    .ex_mispred(ex_mispred), .ex_idx(ex_idx), .br_cnt(br_a), .miss_cnt(miss_a));

  gshare_bpu #(.HIST_W(2), .PC_W(32), .PC_LSB(2), .GSHARE(1'b0), .CNT_W(2), .INIT_ST(2'b01)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .if_br(if_br), .if_pc(if_pc),
    .br_pre(pre_b), .pred_idx(idx_b), .ex_br(ex_br), .ex_taken(ex_taken),
    .ex_mispred(ex_mispred), .ex_idx(ex_idx[1:0]), .br_cnt(br_b), .miss_cnt(miss_b));

  // Reference model, one slot per configuration.
  int hw   [2] = '{3, 2};
  int gs   [2] = '{1, 0};
  int cmax [2] = '{15, 3};
  int m_spec [2];
  int m_arch [2];
  int m_br   [2];
  int m_miss [2];
  int m_pht  [2][8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      m_spec[c] = 0; m_arch[c] = 0; m_br[c] = 0; m_miss[c] = 0;
      for (int e = 0; e < 8; e++) m_pht[c][e] = 1;
    end
  endtask

  function automatic int m_idx(input int c);
    int n;
    n = 1 << hw[c];
    if (gs[c] != 0) return (int'(if_pc >> 2) % n) ^ m_spec[c];
    return m_spec[c];
  endfunction

  function automatic int m_pred(input int c);
    return (if_br && m_pht[c][m_idx(c)] >= 2) ? 1 : 0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic m_step();
    for (int c = 0; c < 2; c++) begin
      int n, p, e;
      n = 1 << hw[c];
      p = m_pred(c);
      if (!stall) begin
        if (ex_br) begin
          e = int'(ex_idx) % n;
          if (ex_taken) m_pht[c][e] = (m_pht[c][e] < 3) ? m_pht[c][e] + 1 : 3;
          else          m_pht[c][e] = (m_pht[c][e] > 0) ? m_pht[c][e] - 1 : 0;
          m_arch[c] = (m_arch[c] * 2 + (ex_taken ? 1 : 0)) % n;
          if (m_br[c] < cmax[c]) m_br[c]++;
          if (ex_mispred && m_miss[c] < cmax[c]) m_miss[c]++;
        end
        if (ex_br && ex_mispred) m_spec[c] = m_arch[c];
        else if (if_br)          m_spec[c] = (m_spec[c] * 2 + p) % n;
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, "_pre_a"},  32'(pre_a),  32'(m_pred(0)));
    check({ph, "_idx_a"},  32'(idx_a),  32'(m_idx(0)));
    check({ph, "_br_a"},   32'(br_a),   32'(m_br[0]));
    check({ph, "_miss_a"}, 32'(miss_a), 32'(m_miss[0]));
    check({ph, "_pre_b"},  32'(pre_b),  32'(m_pred(1)));
    check({ph, "_idx_b"},  32'(idx_b),  32'(m_idx(1)));
    check({ph, "_br_b"},   32'(br_b),   32'(m_br[1]));
    check({ph, "_miss_b"}, 32'(miss_b), 32'(m_miss[1]));
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic step(input string ph);
    #1;
    check_outputs(ph);
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    m_reset();
    check_outputs("arst");
    check("arst_br_zero",  32'(br_a), 32'd0);
    #1 rst = 1'b0;
  endtask

  task automatic drive(input logic s, input logic ib, input logic [31:0] pc,
                       input logic eb, input logic et, input logic em, input logic [2:0] ei);
    stall = s; if_br = ib; if_pc = pc; ex_br = eb; ex_taken = et; ex_mispred = em; ex_idx = ei;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state: every entry weakly not-taken, counters zero.
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    #1;
    check("rst_pre_a", 32'(pre_a), 32'd0);
    check("rst_idx_a", 32'(idx_a), 32'd0);
    check("rst_br_b",  32'(br_b),  32'd0);
    if_br = 1'b0;
    @(negedge clk);

    // Train entry 0 taken three times; speculative history stays zero.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0);
      step("train");
    end
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    #1;
    check("train_pre_b", 32'(pre_b), 32'd1);
    check("train_idx_b", 32'(idx_b), 32'd0);
    check("train_pre_a", 32'(pre_a), 32'd1);
    step("train_pred");

    // Counter saturation on the 2-bit configuration.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 3'd4);
      step("sat");
    end
    #1;
    check("sat_br_b",   32'(br_b),   32'd3);
    check("sat_miss_b", 32'(miss_b), 32'd3);

    // Stall with all activity requested: nothing may move.
    drive(1'b1, 1'b1, 32'h1c, 1'b1, 1'b1, 1'b1, 3'd2);
    step("stall");
    step("stall2");

    // Randomized traffic with occasional asynchronous resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 6), $urandom & 32'h3c,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
